// File: rtl/btn_gesture_pkg.sv
// Board-level defaults for the button gesture decoder (12 MHz HFOSC),
// plus a range check for the tick parameters.
package btn_gesture_pkg;

  localparam int unsigned BTN_CLK_HZ     = 12_000_000;
  localparam int unsigned BTN_TW         = 24;
  localparam int unsigned BTN_LONG_TICKS = BTN_CLK_HZ / 2;  // 0.5 s
  localparam int unsigned BTN_GAP_TICKS  = BTN_CLK_HZ / 4;  // 0.25 s

  function automatic bit ticks_ok(input int unsigned ticks, input int unsigned tw);
    return (ticks >= 2) && (64'(ticks) < (64'd1 << tw));
  endfunction

endpackage

// File: rtl/btn_gesture_if.sv
// Button-to-boot-FSM signal bundle: filtered button in, gesture events out.
interface btn_gesture_if;

  logic btn_v;
  logic btn_f;
  logic btn_r;
  logic evt_short;
  logic evt_long;
  logic evt_double;
  logic held;
  logic busy;

  modport master (
    output btn_v, btn_f, btn_r,
    input  evt_short, evt_long, evt_double, held, busy
  );

  modport slave (
    input  btn_v, btn_f, btn_r,
    output evt_short, evt_long, evt_double, held, busy
  );

endinterface

// File: rtl/btn_gesture_timer.sv
// gesture_timer: TW-bit up-counter with synchronous clear (priority) and enable.
module gesture_timer #(
  parameter int unsigned TW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [TW-1:0] o_cnt
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/btn_gesture.sv
// Button gesture decoder: short / long / double press events and hold level.
// Define BTN_DOUBLE_EN to build the GAP/PRESS2 states and a live evt_double.
module btn_gesture
  import btn_gesture_pkg::*;
#(
  parameter int unsigned TW         = BTN_TW,
  parameter int unsigned LONG_TICKS = BTN_LONG_TICKS,
  parameter int unsigned GAP_TICKS  = BTN_GAP_TICKS
) (
  input  logic          clk,
  input  logic          rst_n,
  btn_gesture_if.slave  bus
);

  if (!ticks_ok(LONG_TICKS, TW) || !ticks_ok(GAP_TICKS, TW)) begin : g_bad_ticks
    $error("btn_gesture: LONG_TICKS/GAP_TICKS must lie in 2 .. 2^TW-1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_HOLD
`ifdef BTN_DOUBLE_EN
    ,
    S_GAP,
    S_PRESS2
`endif
  } state_t;

  localparam logic [TW-1:0] LONG_CMP = TW'(LONG_TICKS - 1);
`ifdef BTN_DOUBLE_EN
  localparam logic [TW-1:0] GAP_CMP  = TW'(GAP_TICKS - 1);
`endif

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_short_nxt;
  logic          w_long_nxt;
  logic          w_double_nxt;
  logic          w_tmr_clr;
  logic          w_tmr_en;
  logic [TW-1:0] w_cnt;
  logic          r_evt_short;
  logic          r_evt_long;
  logic          r_evt_double;
  logic          r_held;
  logic          r_busy;

  // Release beats the long compare, press beats the gap compare.
  always_comb begin
    w_state_nxt  = r_state;
    w_short_nxt  = 1'b0;
    w_long_nxt   = 1'b0;
    w_double_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.btn_f) begin
          w_state_nxt = S_PRESS;
        end else if (!bus.btn_v) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_PRESS: begin
        if (bus.btn_r) begin
`ifdef BTN_DOUBLE_EN
          w_state_nxt = S_GAP;
`else
          w_state_nxt = S_IDLE;
          w_short_nxt = 1'b1;
`endif
        end else if (w_cnt == LONG_CMP) begin
          w_state_nxt = S_HOLD;
          w_long_nxt  = 1'b1;
        end
      end
`ifdef BTN_DOUBLE_EN
      S_GAP: begin
        if (bus.btn_f) begin
          w_state_nxt = S_PRESS2;
        end else if (w_cnt == GAP_CMP) begin
          w_state_nxt = S_IDLE;
          w_short_nxt = 1'b1;
        end
      end
      S_PRESS2: begin
        if (bus.btn_r) begin
          w_state_nxt  = S_IDLE;
          w_double_nxt = 1'b1;
        end else if (w_cnt == LONG_CMP) begin
          w_state_nxt = S_HOLD;
          w_long_nxt  = 1'b1;
        end
      end
`endif
      S_HOLD: begin
        if (bus.btn_r) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_tmr_clr = (w_state_nxt != r_state);
`ifdef BTN_DOUBLE_EN
  assign w_tmr_en  = (r_state == S_PRESS) || (r_state == S_GAP) || (r_state == S_PRESS2);
`else
  assign w_tmr_en  = (r_state == S_PRESS);
`endif

  gesture_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_tmr_clr),
    .i_en  (w_tmr_en),
    .o_cnt (w_cnt)
  );

  // Outputs are registered from next-state so held/busy align with the events.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_evt_short  <= 1'b0;
      r_evt_long   <= 1'b0;
      r_evt_double <= 1'b0;
      r_held       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_evt_short  <= w_short_nxt;
      r_evt_long   <= w_long_nxt;
      r_evt_double <= w_double_nxt;
      r_held       <= (w_state_nxt == S_HOLD);
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.evt_short  = r_evt_short;
  assign bus.evt_long   = r_evt_long;
`ifdef BTN_DOUBLE_EN
  assign bus.evt_double = r_evt_double;
`else
  assign bus.evt_double = 1'b0;
`endif
  assign bus.held       = r_held;
  assign bus.busy       = r_busy;

endmodule
